// File: rtl/pll_reset_gen_pkg.sv
// -----------------------------------------------------------------------------
// pll_reset_gen_pkg
// Shared definitions for the lock-qualified reset sequencer.
//   - PRG_STATE_W : width of the exported FSM state
//   - prg_state_e : IDLE=0, STABLE=1, HOLD=2, RUN=3
//   - prg_max     : elaboration-time helper used to size the cycle counter
// -----------------------------------------------------------------------------
package pll_reset_gen_pkg;

  localparam int PRG_STATE_W = 2;

  typedef enum logic [PRG_STATE_W-1:0] {
    PRG_IDLE   = 2'd0,
    PRG_STABLE = 2'd1,
    PRG_HOLD   = 2'd2,
    PRG_RUN    = 2'd3
  } prg_state_e;

  function automatic int prg_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// -----------------------------------------------------------------------------
// sync_ff2
// Two-flop synchronizer for a single asynchronous status bit. Both flops
// clear to 0 under a synchronous active-low reset.
//   clk_i  : destination clock
//   rst_ni : synchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output (two destination-clock edges of latency)
// -----------------------------------------------------------------------------
module sync_ff2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_gen.sv
// -----------------------------------------------------------------------------
// pll_reset_gen
// Lock-qualified reset sequencer for logic clocked by a PLL output. The PLL
// lock flag is synchronized, must stay high for STABLE_CYCLES, then reset is
// held for HOLD_CYCLES more before release. Any lock loss returns to IDLE.
//
// Ports:
//   clock        : PLL output clock, rising edge
//   reset_n      : synchronous active-low reset
//   locked_async : PLL lock flag, asynchronous to clock
//   clear_count  : synchronous clear of loss_count
//   rst_out      : active-high design reset (registered)
//   ready        : high iff in RUN (registered)
//   state        : FSM state (IDLE=0, STABLE=1, HOLD=2, RUN=3)
//   loss_count   : saturating count of lock losses seen in HOLD or RUN
//
// Build option: define PLL_RESET_GEN_LOSS_CNT_EN to build the lock-loss
// counter. Without it loss_count is tied to 0 and clear_count is ignored.
// -----------------------------------------------------------------------------
module pll_reset_gen
  import pll_reset_gen_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   locked_async,
  input  logic                   clear_count,
  output logic                   rst_out,
  output logic                   ready,
  output logic [PRG_STATE_W-1:0] state,
  output logic [CNT_W-1:0]       loss_count
);

  localparam int CYC_W = $clog2(prg_max(STABLE_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] HOLD_LAST   = CYC_W'(HOLD_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ZERO    = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1'b1);

  logic       lock_s;
  prg_state_e state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic       rst_q, rst_d;
  logic       ready_q, ready_d;

  sync_ff2 u_lock_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (locked_async),
    .q_o    (lock_s)
  );

  // Next-state and cycle-counter logic; lock loss takes priority over expiry.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    case (state_q)
      PRG_IDLE: begin
        cyc_d = CYC_ZERO;
        if (lock_s) begin
          state_d = PRG_STABLE;
        end else begin
          state_d = PRG_IDLE;
        end
      end
      PRG_STABLE: begin
        if (!lock_s) begin
          state_d = PRG_IDLE;
          cyc_d   = CYC_ZERO;
        end else if (cyc_q == STABLE_LAST) begin
          state_d = PRG_HOLD;
          cyc_d   = CYC_ZERO;
        end else begin
          state_d = PRG_STABLE;
          cyc_d   = cyc_q + CYC_ONE;
        end
      end
      PRG_HOLD: begin
        if (!lock_s) begin
          state_d = PRG_IDLE;
          cyc_d   = CYC_ZERO;
        end else if (cyc_q == HOLD_LAST) begin
          state_d = PRG_RUN;
          cyc_d   = CYC_ZERO;
        end else begin
          state_d = PRG_HOLD;
          cyc_d   = cyc_q + CYC_ONE;
        end
      end
      PRG_RUN: begin
        cyc_d = CYC_ZERO;
        if (!lock_s) begin
          state_d = PRG_IDLE;
        end else begin
          state_d = PRG_RUN;
        end
      end
      default: begin
        state_d = PRG_IDLE;
        cyc_d   = CYC_ZERO;
      end
    endcase
  end

  // rst_out/ready are decoded from the next state so they land on the same
  // edge as the state register without a combinational path from state_q.
  always_comb begin
    rst_d   = (state_d != PRG_RUN);
    ready_d = (state_d == PRG_RUN);
  end

  // FSM state, cycle counter and the registered reset/ready outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= PRG_IDLE;
      cyc_q   <= CYC_ZERO;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign state   = state_q;
  assign rst_out = rst_q;
  assign ready   = ready_q;

`ifdef PLL_RESET_GEN_LOSS_CNT_EN
  logic             loss_event_s;
  logic [CNT_W-1:0] loss_q, loss_d;

  // Drops in STABLE are jitter; only drops after qualification count.
  assign loss_event_s = !lock_s && ((state_q == PRG_HOLD) || (state_q == PRG_RUN));

  // Saturating loss counter; a clear coinciding with a loss leaves 1.
  always_comb begin
    loss_d = loss_q;
    if (clear_count && loss_event_s) begin
      loss_d = CNT_W'(1'b1);
    end else if (clear_count) begin
      loss_d = {CNT_W{1'b0}};
    end else if (loss_event_s && (loss_q != {CNT_W{1'b1}})) begin
      loss_d = loss_q + CNT_W'(1'b1);
    end else begin
      loss_d = loss_q;
    end
  end

  // Loss counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      loss_q <= {CNT_W{1'b0}};
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_count = loss_q;
`else
  logic unused_clear_s;
  assign unused_clear_s = clear_count;
  assign loss_count     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_reset_gen.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_gen
// Self-checking bench. The reference model tracks only how many consecutive
// edges the FSM has seen a synchronized lock; the expected state follows
// from that run length alone, and a lock loss counts when the run had gone
// past the STABLE window.
// -----------------------------------------------------------------------------
module tb_pll_reset_gen;

  localparam int S    = 8;
  localparam int H    = 4;
  localparam int CW   = 2;
  localparam int MAXC = 3;
`ifdef PLL_RESET_GEN_LOSS_CNT_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  logic          clk          = 1'b0;
  logic          reset_n      = 1'b0;
  logic          locked_async = 1'b0;
  logic          clear_count  = 1'b0;
  logic          rst_out;
  logic          ready;
  logic [1:0]    state;
  logic [CW-1:0] loss_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // reference model: 2-deep lock delay line, lock run length, loss tally
  bit m_p0   = 1'b0;
  bit m_p1   = 1'b0;
  int m_run  = 0;
  int m_loss = 0;

  pll_reset_gen #(
    .STABLE_CYCLES (S),
    .HOLD_CYCLES   (H),
    .CNT_W         (CW)
  ) dut (
    .clock        (clk),
    .reset_n      (reset_n),
    .locked_async (locked_async),
    .clear_count  (clear_count),
    .rst_out      (rst_out),
    .ready        (ready),
    .state        (state),
    .loss_count   (loss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int exp_state(input int run);
    if (run == 0)          return 0;
    else if (run <= S)     return 1;
    else if (run <= S + H) return 2;
    else                   return 3;
  endfunction

  function automatic int exp_loss();
    return LC_EN ? m_loss : 0;
  endfunction

  // model update on each active edge
  always @(posedge clk) begin : model
    bit lost;
    if (!reset_n) begin
      m_p0 = 1'b0; m_p1 = 1'b0; m_run = 0; m_loss = 0;
    end else begin
      lost = 1'b0;
      if (m_p1) begin
        if (m_run <= S + H) m_run++;
      end else begin
        lost  = (m_run > S);
        m_run = 0;
      end
      if (clear_count)                m_loss = lost ? 1 : 0;
      else if (lost && m_loss < MAXC) m_loss++;
      m_p1 = m_p0;
      m_p0 = locked_async;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin : compare
    int es;
    if (chk_en) begin
      es = exp_state(m_run);
      check("state",      state,      es);
      check("rst_out",    rst_out,    (es != 3) ? 1 : 0);
      check("ready",      ready,      (es == 3) ? 1 : 0);
      check("loss_count", loss_count, exp_loss());
    end
  end

  logic [7:0] trace;
  logic [1:0] last_st;

  // edges from the lock-raising negedge (edge 0 next) until ready; -1 on timeout
  task automatic measure_run(output int lat);
    lat = -1;
    trace = 8'h00;
    last_st = 2'd0;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (state != last_st) begin
        trace = {trace[5:0], state};
        last_st = state;
      end
      if (ready && lat < 0) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; locked_async = 1'b0; clear_count = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int lat;
    int hold_left;
    bit found;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_rst_out", rst_out, 1);
    check("reset_ready",   ready,   0);
    check("reset_state",   state,   0);

    // 1: basic lock-up
    reset_n = 1'b1; locked_async = 1'b1;
    measure_run(lat);
    check("lockup_latency", lat, 14);
    check("state_trace", trace, 8'h1B);

    // 2: jitter midway through STABLE
    do_reset();
    locked_async = 1'b1;
    repeat (6) @(negedge clk);
    locked_async = 1'b0;
    repeat (3) @(negedge clk);
    locked_async = 1'b1;
    measure_run(lat);
    check("jitter_latency", lat, 14);
    check("jitter_loss", loss_count, 0);

    // 3: loss in RUN and relock
    @(negedge clk);
    locked_async = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("loss_f1_rst_out", rst_out, 0);
    @(posedge clk); #1;
    check("loss_f2_rst_out", rst_out, 1);
    check("loss_f2_state",   state,   0);
    check("loss_f2_count",   loss_count, LC_EN ? 1 : 0);
    @(negedge clk);
    locked_async = 1'b1;
    measure_run(lat);
    check("relock_latency", lat, 14);

    // 4: saturation, clear, clear-with-loss
    do_reset();
    for (int k = 0; k < 5; k++) begin
      locked_async = 1'b1;
      measure_run(lat);
      @(negedge clk);
      locked_async = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("sat_count", loss_count, LC_EN ? 3 : 0);
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    check("clear_count", loss_count, 0);
    locked_async = 1'b1;
    measure_run(lat);
    @(negedge clk);
    locked_async = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    check("clear_with_loss", loss_count, LC_EN ? 1 : 0);

    // 5: reset pulse while in HOLD
    do_reset();
    locked_async = 1'b1;
    found = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (state == 2'd2) begin found = 1'b1; break; end
    end
    check("reach_hold", found, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_rst_out", rst_out, 1);
    check("midreset_ready",   ready,   0);
    check("midreset_state",   state,   0);
    check("midreset_count",   loss_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    measure_run(lat);
    check("midreset_latency", lat, 14);

    // 6: randomized traffic against the model
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hold_left == 0) begin
        locked_async = ~locked_async;
        hold_left = locked_async ? $urandom_range(1, 30) : $urandom_range(1, 5);
      end
      hold_left--;
      clear_count = ($urandom_range(0, 19) == 0);
      reset_n     = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    reset_n = 1'b1; clear_count = 1'b0;
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
